jtkiwi_tilescan: RTL and testbench
==================================

// Module: jtkiwi_tilescan
// PURPOSE
// Per-scanline tile-map scanner, upstream of the tile draw engine. On each
// line start it reads the 16x16 tile map from VRAM and issues one
// draw request per visible column: code, attr, xpos and ysub. It then waits on the
// engine's busy/draw handshake. One clock domain; line-buffer flipping is out of scope.
// PARAMETERS
// COLS    17   draw requests per line (256 px + one partial tile)
// VRAM_AW 11   VRAM word address width: {attr_sel, row[4:0], col[4:0]}
// PORTS
// clk        in   1   system clock
// rst_n      in   1   asynchronous, active-low reset
// hs         in   1   line-start strobe, 1-cycle pulse
// vdump      in   9   line to be drawn
// xscroll    in   9   global horizontal scroll
// yscroll    in   9   global vertical scroll
// flip       in   1   screen flip
// vram_addr  out  11  VRAM read address
// vram_data  in   16  VRAM read data, valid 1 cycle after vram_addr
// draw       out  1   draw request pulse to tile engine
// busy       in   1   tile engine busy
// code       out  16  tile code, held from draw until next request
// attr       out  16  tile attributes, held likewise
// xpos       out  9   line-buffer start pixel
// ysub       out  4   row inside tile
// done       out  1   high when all COLS requests accepted for this line
// BEHAVIOUR
// - Reset: draw=0, done=1, vram_addr=0, code=attr=0, xpos=0, ysub=0, FSM=IDLE, n=0.
// - hs latched values: yline = flip ? ~vdump : vdump; yeff = yline+yscroll (9b wrap).
//   Also row=yeff[8:4], ysub=yeff[3:0]^{4{flip}} (pre-compensates engine's flip XOR).
// - Column n (0..COLS-1): col=(xscroll[8:4]+n)[4:0] wrapping at 32; xpos=n*16-xscroll[3:0] mod 512.
// - Addresses: code word at {1'b0,row,col}; attr word at {1'b1,row,col}.
// - FSM:
//   IDLE  : on hs -> clear done, n=0, ADDR_C.
//   ADDR_C: vram_addr=code addr -> ADDR_A.
//   ADDR_A: vram_addr=attr addr; capture vram_data into code_q -> CAPT.
//   CAPT  : capture vram_data into attr_q -> REQ.
//   REQ   : if !busy, load code/attr/xpos outputs, draw=1 for exactly 1 cycle -> ACK.
//   ACK   : one guard cycle, ignore busy (engine raises busy the cycle after draw) -> WAITB.
//   WAITB : when !busy, n==COLS-1 -> done=1, IDLE; else n++, ADDR_C.
// - Prefetch: VRAM reads for column n+1 are not overlapped with engine drawing
//   of column n. Outputs are held stable while the engine is busy.
// - hs during any non-IDLE state: abort current line, restart at n=0 with new latches.
//   No draw issues in that cycle. A draw pulse already issued is not retracted.
// - hs and an in-flight done in the same cycle: hs wins, done stays 0.
// - busy stuck high: FSM waits in REQ/WAITB indefinitely. No timeout.
// - rst_n low mid-line: immediate return to reset values. Outputs change asynchronously.
// - Per-request latency from leaving WAITB/IDLE to draw: 3 cycles + busy wait.
// STRUCTURE
// - Shared pkg jtkiwi_pkg: FSM state enum and TILE_W=16.
//   Also the VRAM attr_sel bit position, shared with the CPU VRAM mux.
// - Single module, no sub-modules. Address/xpos arithmetic is inline combinational.
// TESTING
// - Line start, no scroll: vdump=0x25, xscroll=0, yscroll=0, busy=0.
//   -> 17 draws; xpos=0,16..256; ysub=5; addresses row=2, col=0..16 (code), +0x400 (attr).
// - Fine scroll: xscroll=0x1F3.
//   -> col sequence 31,0,1..15; xpos=0x1FD,0x00D,0x01D...; wrap correct at 512.
// - Flip: vdump=0x10, yscroll=0, flip=1.
//   -> yline=0x1EF, row=30, ysub=0xF^0xF=0; 17 draws.
// - Handshake: model engine with busy high 20 cycles after each draw.
//   -> exactly one draw per busy window; never draw while busy; done after 17th acceptance.
// - Abort: hs again after 5th draw.
//   -> n restarts at 0, done stays 0, 17 further draws.
// - Reset: pull rst_n low during WAITB.
//   -> draw=0, done=1 asynchronously; next hs scans normally.

Source files
------------

// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the tile-map scanner and the CPU-side VRAM mux.
package jtkiwi_pkg;

    localparam int TILE_W        = 16;
    // VRAM word address bit that selects the attribute half of the map
    localparam int VRAM_ATTR_BIT = 10;

    typedef logic [2:0] scan_st_t;

    localparam scan_st_t ST_IDLE   = 3'd0;
    localparam scan_st_t ST_ADDR_C = 3'd1;
    localparam scan_st_t ST_ADDR_A = 3'd2;
    localparam scan_st_t ST_CAPT   = 3'd3;
    localparam scan_st_t ST_REQ    = 3'd4;
    localparam scan_st_t ST_ACK    = 3'd5;
    localparam scan_st_t ST_WAITB  = 3'd6;

endpackage

// File: rtl/jtkiwi_tilescan.sv
// Per-scanline tile-map scanner: reads code/attr words from VRAM for each
// visible column and hands them one at a time to the tile draw engine.
module jtkiwi_tilescan
    import jtkiwi_pkg::*;
#(
    parameter int COLS    = 17,
    parameter int VRAM_AW = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hs,
    input  logic [8:0]         vdump,
    input  logic [8:0]         xscroll,
    input  logic [8:0]         yscroll,
    input  logic               flip,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [15:0]        vram_data,
    output logic               draw,
    input  logic               busy,
    output logic [15:0]        code,
    output logic [15:0]        attr,
    output logic [8:0]         xpos,
    output logic [3:0]         ysub,
    output logic               done
);

    localparam int NW = $clog2(COLS);

    scan_st_t      st;
    logic [NW-1:0] n;
    logic [4:0]    row;
    logic [8:0]    xs_q;
    logic [15:0]   code_q;
    logic [15:0]   attr_q;

    logic [8:0]    yline;
    logic [8:0]    yeff;
    logic [4:0]    col;
    logic [8:0]    xpos_nx;
    logic          last;

    always_comb begin
        yline   = flip ? ~vdump : vdump;
        yeff    = yline + yscroll;
        col     = xs_q[8:4] + 5'(n);
        xpos_nx = 9'(n) * 9'(TILE_W) - {5'd0, xs_q[3:0]};
        last    = (n == NW'(COLS - 1));
    end

    // Address is decoded straight from state so VRAM data lines up one cycle later
    always_comb begin
        vram_addr                = '0;
        vram_addr[9:0]           = {row, col};
        vram_addr[VRAM_ATTR_BIT] = (st == ST_ADDR_A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            n      <= '0;
            row    <= '0;
            xs_q   <= '0;
            code_q <= '0;
            attr_q <= '0;
            draw   <= 1'b0;
            done   <= 1'b1;
            code   <= '0;
            attr   <= '0;
            xpos   <= '0;
            ysub   <= '0;
        end else begin
            draw <= 1'b0;
            if (hs) begin
                // ysub is pre-flipped because the engine XORs it again on flip
                row  <= yeff[8:4];
                ysub <= yeff[3:0] ^ {4{flip}};
                xs_q <= xscroll;
                n    <= '0;
                done <= 1'b0;
                st   <= ST_ADDR_C;
            end else begin
                case (st)
                    ST_IDLE: ;
                    ST_ADDR_C: st <= ST_ADDR_A;
                    ST_ADDR_A: begin
                        code_q <= vram_data;
                        st     <= ST_CAPT;
                    end
                    ST_CAPT: begin
                        attr_q <= vram_data;
                        st     <= ST_REQ;
                    end
                    ST_REQ: begin
                        if (!busy) begin
                            code <= code_q;
                            attr <= attr_q;
                            xpos <= xpos_nx;
                            draw <= 1'b1;
                            st   <= ST_ACK;
                        end
                    end
                    // engine only raises busy the cycle after draw, so skip one look
                    ST_ACK: st <= ST_WAITB;
                    ST_WAITB: begin
                        if (!busy) begin
                            if (last) begin
                                done <= 1'b1;
                                st   <= ST_IDLE;
                            end else begin
                                n  <= n + 1'b1;
                                st <= ST_ADDR_C;
                            end
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtkiwi_tilescan.sv
// Bench for jtkiwi_tilescan: VRAM and tile engine models plus a draw scoreboard.
module tb_jtkiwi_tilescan;

    logic        clk;
    logic        rst_n;
    logic        hs;
    logic [8:0]  vdump;
    logic [8:0]  xscroll;
    logic [8:0]  yscroll;
    logic        flip;
    logic [10:0] vram_addr;
    logic [15:0] vram_data;
    logic        draw;
    logic        busy;
    logic [15:0] code;
    logic [15:0] attr;
    logic [8:0]  xpos;
    logic [3:0]  ysub;
    logic        done;

    typedef struct packed {
        logic [15:0] code;
        logic [15:0] attr;
        logic [8:0]  xpos;
        logic [3:0]  ysub;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   draws  = 0;
    int   busy_len = 0;
    int   busy_cnt;
    logic draw_d = 1'b0;

    jtkiwi_tilescan #(.COLS(17), .VRAM_AW(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs        (hs),
        .vdump     (vdump),
        .xscroll   (xscroll),
        .yscroll   (yscroll),
        .flip      (flip),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .draw      (draw),
        .busy      (busy),
        .code      (code),
        .attr      (attr),
        .xpos      (xpos),
        .ysub      (ysub),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM content encodes its own address so any address error shows up in code/attr
    function automatic logic [15:0] vmem(input logic [10:0] a);
        return {(a[10] ? 4'hA : 4'hC), 1'b0, a};
    endfunction

    always @(posedge clk) vram_data <= vmem(vram_addr);

    // Tile engine: busy for busy_len cycles after sampling a draw
    always @(posedge clk) begin
        if (!rst_n)
            busy_cnt <= 0;
        else if (draw)
            busy_cnt <= busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign busy = (busy_cnt != 0);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endfunction

    // Monitor: every draw pulse is checked against the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && draw) begin
            draws++;
            chk("draw_while_busy", {31'd0, busy}, 32'd0);
            chk("draw_single_pulse", {31'd0, draw_d}, 32'd0);
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_draw: got draw code=%0h xpos=%0h, expected no draw", code, xpos);
            end else begin
                e = q.pop_front();
                chk("code", {16'd0, code}, {16'd0, e.code});
                chk("attr", {16'd0, attr}, {16'd0, e.attr});
                chk("xpos", {23'd0, xpos}, {23'd0, e.xpos});
                chk("ysub", {28'd0, ysub}, {28'd0, e.ysub});
            end
        end
        draw_d = rst_n && draw;
    end

    task automatic push_line(input logic [8:0] vd, input logic [8:0] xs, input logic [8:0] ys, input logic fl);
        logic [8:0]  yl;
        logic [8:0]  ye;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [10:0] a;
        exp_t        e;
        yl  = fl ? ~vd : vd;
        ye  = yl + ys;
        row = ye[8:4];
        for (int n = 0; n < 17; n++) begin
            col    = xs[8:4] + 5'(n);
            a      = {1'b0, row, col};
            e.code = vmem(a);
            e.attr = vmem(a | 11'h400);
            e.xpos = 9'(n * 16) - {5'd0, xs[3:0]};
            e.ysub = ye[3:0] ^ {4{fl}};
            q.push_back(e);
        end
    endtask

    task automatic start_line(input logic [8:0] vd, input logic [8:0] xs, input logic [8:0] ys, input logic fl);
        @(negedge clk);
        vdump   = vd;
        xscroll = xs;
        yscroll = ys;
        flip    = fl;
        push_line(vd, xs, ys, fl);
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        chk("done_cleared_on_hs", {31'd0, done}, 32'd0);
    endtask

    task automatic finish_line(input string nm, input int start_draws);
        int k;
        k = 0;
        while (!(done && q.size() == 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_draw_count"}, 32'(draws - start_draws), 32'd17);
        chk({nm, "_queue_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_draws(input int target);
        int k;
        k = 0;
        while (draws < target && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("draw_wait_reached", {31'd0, (draws >= target)}, 32'd1);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_draw"}, {31'd0, draw}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_vram_addr"}, {21'd0, vram_addr}, 32'd0);
        chk({nm, "_code"}, {16'd0, code}, 32'd0);
        chk({nm, "_attr"}, {16'd0, attr}, 32'd0);
        chk({nm, "_xpos"}, {23'd0, xpos}, 32'd0);
        chk({nm, "_ysub"}, {28'd0, ysub}, 32'd0);
    endtask

    initial begin : stim
        int d0;
        rst_n   = 1'b0;
        hs      = 1'b0;
        vdump   = '0;
        xscroll = '0;
        yscroll = '0;
        flip    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // No scroll: row 2, ysub 5, columns 0..16
        d0 = draws;
        start_line(9'h025, 9'h000, 9'h000, 1'b0);
        finish_line("noscroll", d0);

        // Fine scroll: columns 31,0,1..15 and xpos wrapping below zero
        d0 = draws;
        start_line(9'h025, 9'h1F3, 9'h000, 1'b0);
        finish_line("finescroll", d0);

        // Flip: row 30, ysub 0
        d0 = draws;
        start_line(9'h010, 9'h000, 9'h000, 1'b1);
        finish_line("flip", d0);

        // Engine busy for 20 cycles after each draw, with vertical scroll
        busy_len = 20;
        d0 = draws;
        start_line(9'h037, 9'h008, 9'h044, 1'b0);
        finish_line("handshake", d0);

        // Abort after the 5th draw: restart at column 0 with new latches
        busy_len = 4;
        d0 = draws;
        start_line(9'h060, 9'h010, 9'h000, 1'b0);
        wait_draws(d0 + 5);
        q.delete();
        vdump   = 9'h0B2;
        xscroll = 9'h024;
        yscroll = 9'h007;
        flip    = 1'b0;
        push_line(9'h0B2, 9'h024, 9'h007, 1'b0);
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        chk("abort_done_low", {31'd0, done}, 32'd0);
        d0 = draws;
        finish_line("abort", d0);

        // Reset while the FSM waits on a busy engine
        busy_len = 20;
        d0 = draws;
        start_line(9'h025, 9'h000, 9'h000, 1'b0);
        wait_draws(d0 + 3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midline_reset");
        @(negedge clk);
        q.delete();
        rst_n    = 1'b1;
        busy_len = 0;
        d0 = draws;
        start_line(9'h081, 9'h0A5, 9'h013, 1'b0);
        finish_line("after_reset", d0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal end");
        $fatal(1, "watchdog");
    end

endmodule
